// File: rtl/bma_ctr_seq.sv
// Control sequencer for the block-matching array: IDLE -> INIT (memory preload) -> RUN (load/fill/PE sweep).
// Latency: all outputs registered; decoded from state, counters and en_init sampled at the same edge.
// Backpressure: with BMA_CTR_STALL_EN, stall freezes RUN progress; en_init always overrides stall.
module bma_ctr_seq #(
    parameter int WORD_WIDTH     = 8,
    parameter int LANES          = 4,
    parameter int LOAD_CYCLES    = 4,
    parameter int FILL_CYCLES    = 6,
    parameter int PE_COLS        = 14,
    parameter int CW_WIDTH       = 4,
    parameter int INIT_HOLD      = 6,
    parameter int MEM20_INIT_IDX = 5,
    parameter int MEM20_OFFSET   = 1,
    parameter int BLK_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_init,
    input  logic                        stall,
    input  logic [BLK_W-1:0]            cfg_blocks,
    input  logic [WORD_WIDTH*LANES-1:0] input_raw,
    output logic [WORD_WIDTH*LANES-1:0] input_raw_saved,
    output logic [CW_WIDTH-1:0]         ctr_word,
    output logic                        mem19198_en_input,
    output logic                        mem448_en_input,
    output logic                        mem20_en_input,
    output logic                        mem_init_mode,
    output logic                        en_pe,
    output logic                        busy,
    output logic                        period_done,
    output logic                        done
);

    localparam int P  = LOAD_CYCLES + FILL_CYCLES + PE_COLS;
    localparam int PW = $clog2(P);
    localparam int IW = $clog2(INIT_HOLD + 1);

    localparam logic [PW-1:0]       PH_FILL = PW'(LOAD_CYCLES);
    localparam logic [PW-1:0]       PH_M20  = PW'(LOAD_CYCLES + MEM20_OFFSET);
    localparam logic [PW-1:0]       PH_PE   = PW'(LOAD_CYCLES + FILL_CYCLES);
    localparam logic [PW-1:0]       PH_LAST = PW'(P - 1);
    localparam logic [IW-1:0]       IC_HOLD = IW'(INIT_HOLD);
    localparam logic [IW-1:0]       IC_M20  = IW'(MEM20_INIT_IDX);
    localparam logic [CW_WIDTH-1:0] CW_ONES = '1;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       phase, phase_nxt;
    logic [IW-1:0]       init_cnt, init_cnt_nxt;
    logic [BLK_W-1:0]    blk_cnt, blk_cnt_nxt, cfg_blk, cfg_blk_nxt;
    logic                first0, first0_nxt, first1, first1_nxt;
    logic [CW_WIDTH-1:0] ctr_word_nxt;
    logic                m19_nxt, m448_nxt, m20_nxt, init_mode_nxt, en_pe_nxt;
    logic                busy_nxt, period_done_nxt, done_nxt;
    logic                init_dec;
    logic [IW-1:0]       icnt;
    logic [BLK_W-1:0]    blk_inc;
    logic                last_blk;
    logic [PW-1:0]       pe_k;
    logic                hold;

`ifdef BMA_CTR_STALL_EN
    assign hold = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold = 1'b0;
`endif

    assign blk_inc  = blk_cnt + BLK_W'(1);
    assign last_blk = (cfg_blk != '0) && (blk_inc == cfg_blk);
    assign pe_k     = phase - PH_PE + PW'(1);

    // Next-state and output decode; the INIT pattern is shared by INIT and a RUN abort.
    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        init_cnt_nxt    = init_cnt;
        blk_cnt_nxt     = blk_cnt;
        cfg_blk_nxt     = cfg_blk;
        first0_nxt      = first0;
        first1_nxt      = first1;
        ctr_word_nxt    = '0;
        m19_nxt         = 1'b0;
        m448_nxt        = 1'b0;
        m20_nxt         = 1'b0;
        init_mode_nxt   = 1'b0;
        en_pe_nxt       = 1'b0;
        period_done_nxt = 1'b0;
        done_nxt        = 1'b0;
        busy_nxt        = (state != IDLE);
        init_dec        = 1'b0;
        icnt            = '0;
        case (state)
            IDLE: begin
                if (en_init) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                end
            end
            INIT: begin
                if (en_init) begin
                    init_dec = 1'b1;
                    icnt     = init_cnt;
                end else begin
                    state_nxt    = RUN;
                    phase_nxt    = '0;
                    first0_nxt   = 1'b1;
                    first1_nxt   = 1'b1;
                    blk_cnt_nxt  = '0;
                    cfg_blk_nxt  = cfg_blocks;
                    init_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (en_init) begin
                    // Abort: this cycle already shows the init_cnt=0 pattern.
                    state_nxt = INIT;
                    init_dec  = 1'b1;
                    icnt      = '0;
                    done_nxt  = (phase == PH_LAST) && last_blk;
                end else if (hold) begin
                    init_mode_nxt = mem_init_mode;
                end else begin
                    if (phase < PH_FILL) begin
                        m448_nxt = 1'b1;
                        if (phase == '0) begin
                            first0_nxt = 1'b0;
                            if (first0) begin
                                init_mode_nxt = 1'b1;
                            end else begin
                                ctr_word_nxt = CW_ONES;
                                en_pe_nxt    = 1'b1;
                            end
                        end else if (phase == PW'(1)) begin
                            first1_nxt = 1'b0;
                            en_pe_nxt  = !first1;
                        end
                    end else if (phase < PH_PE) begin
                        m19_nxt = 1'b1;
                        m20_nxt = (phase == PH_M20);
                    end else begin
                        ctr_word_nxt = CW_WIDTH'(pe_k);
                        en_pe_nxt    = 1'b1;
                        m19_nxt      = (phase != PH_LAST);
                    end
                    if (phase == PH_LAST) begin
                        phase_nxt       = '0;
                        period_done_nxt = 1'b1;
                        blk_cnt_nxt     = blk_inc;
                        if (last_blk) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        phase_nxt = phase + PW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (init_dec) begin
            m19_nxt       = 1'b1;
            init_mode_nxt = 1'b1;
            en_pe_nxt     = (icnt <= IW'(1));
            ctr_word_nxt  = (icnt == '0) ? CW_ONES : '0;
            m20_nxt       = (icnt == IC_M20);
            init_cnt_nxt  = (icnt >= IC_HOLD) ? icnt : icnt + IW'(1);
        end
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            phase             <= '0;
            init_cnt          <= '0;
            blk_cnt           <= '0;
            cfg_blk           <= '0;
            first0            <= 1'b0;
            first1            <= 1'b0;
            input_raw_saved   <= '0;
            ctr_word          <= '0;
            mem19198_en_input <= 1'b0;
            mem448_en_input   <= 1'b0;
            mem20_en_input    <= 1'b0;
            mem_init_mode     <= 1'b0;
            en_pe             <= 1'b0;
            busy              <= 1'b0;
            period_done       <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= state_nxt;
            phase             <= phase_nxt;
            init_cnt          <= init_cnt_nxt;
            blk_cnt           <= blk_cnt_nxt;
            cfg_blk           <= cfg_blk_nxt;
            first0            <= first0_nxt;
            first1            <= first1_nxt;
            input_raw_saved   <= input_raw;
            ctr_word          <= ctr_word_nxt;
            mem19198_en_input <= m19_nxt;
            mem448_en_input   <= m448_nxt;
            mem20_en_input    <= m20_nxt;
            mem_init_mode     <= init_mode_nxt;
            en_pe             <= en_pe_nxt;
            busy              <= busy_nxt;
            period_done       <= period_done_nxt;
            done              <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bma_ctr_seq.sv
// Bench for bma_ctr_seq: directed sequences with literal expectations, then random stimulus.
// A period-table reference model predicts every registered output on every cycle.
// Inputs driven on the falling edge; outputs sampled 1-2 time units after the rising edge.
module tb_bma_ctr_seq;

    localparam int L    = 4;
    localparam int F    = 6;
    localparam int PC   = 14;
    localparam int P    = L + F + PC;
    localparam int CW   = 4;
    localparam int IH   = 6;
    localparam int M20I = 5;
    localparam int M20O = 1;
`ifdef BMA_CTR_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_init = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] cfg_blocks = '0;
    logic [31:0] input_raw = '0;
    logic [31:0] input_raw_saved;
    logic [3:0]  ctr_word;
    logic        mem19198_en_input, mem448_en_input, mem20_en_input;
    logic        mem_init_mode, en_pe, busy, period_done, done;

    bma_ctr_seq dut (
        .clk(clk), .rst_n(rst_n), .en_init(en_init), .stall(stall),
        .cfg_blocks(cfg_blocks), .input_raw(input_raw),
        .input_raw_saved(input_raw_saved), .ctr_word(ctr_word),
        .mem19198_en_input(mem19198_en_input), .mem448_en_input(mem448_en_input),
        .mem20_en_input(mem20_en_input), .mem_init_mode(mem_init_mode),
        .en_pe(en_pe), .busy(busy), .period_done(period_done), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output pattern of an ordinary (not first) period, indexed by phase.
    int tab_ctr[P];
    bit tab_pe[P], tab_448[P], tab_19[P], tab_20[P];

    initial begin
        for (int p = 0; p < P; p++) begin
            tab_ctr[p] = 0; tab_pe[p] = 0; tab_448[p] = 0; tab_19[p] = 0; tab_20[p] = 0;
            if (p < L) begin
                tab_448[p] = 1;
                if (p == 0) begin tab_ctr[p] = (1 << CW) - 1; tab_pe[p] = 1; end
                if (p == 1) tab_pe[p] = 1;
            end else if (p < L + F) begin
                tab_19[p] = 1;
                tab_20[p] = (p == L + M20O);
            end else begin
                tab_ctr[p] = p - L - F + 1;
                tab_pe[p]  = 1;
                tab_19[p]  = (p != P - 1);
            end
        end
        chk("tab_ctr_p0", tab_ctr[0], 15);
        chk("tab_ctr_p10", tab_ctr[10], 1);
        chk("tab_ctr_p23", tab_ctr[23], 14);
        chk("tab_m19_p23", tab_19[23], 0);
        chk("tab_m20_p5", tab_20[5], 1);
    end

    // Reference model state and expected outputs.
    int m_mode = 0, m_icnt = 0, m_ph = 0, m_blk = 0, m_cfg = 0;
    bit m_f0 = 0, m_f1 = 0;
    int e_ctr = 0;
    bit e_19 = 0, e_448 = 0, e_20 = 0, e_im = 0, e_pe = 0, e_busy = 0, e_pd = 0, e_done = 0;
    logic [31:0] e_raw = '0;

    task automatic init_out(input int c);
        e_19  = 1;
        e_im  = 1;
        e_ctr = (c == 0) ? 15 : 0;
        e_pe  = (c <= 1);
        e_20  = (c == M20I);
    endtask

    always @(posedge clk) begin
        bit prev_im;
        bit fin;
        prev_im = e_im;
        e_ctr = 0; e_19 = 0; e_448 = 0; e_20 = 0; e_im = 0; e_pe = 0; e_pd = 0; e_done = 0;
        if (!rst_n) begin
            m_mode = 0; m_icnt = 0; m_ph = 0; m_blk = 0; m_cfg = 0; m_f0 = 0; m_f1 = 0;
            e_busy = 0; e_raw = '0;
        end else begin
            e_raw  = input_raw;
            e_busy = (m_mode != 0);
            case (m_mode)
                0: if (en_init) begin m_mode = 1; m_icnt = 0; end
                1: begin
                    if (en_init) begin
                        init_out(m_icnt);
                        m_icnt = (m_icnt < IH) ? m_icnt + 1 : IH;
                    end else begin
                        m_mode = 2; m_ph = 0; m_f0 = 1; m_f1 = 1;
                        m_blk = 0; m_cfg = cfg_blocks; m_icnt = 0;
                    end
                end
                default: begin
                    fin = (m_ph == P - 1) && (m_cfg != 0) && (((m_blk + 1) % 65536) == m_cfg);
                    if (en_init) begin
                        init_out(0);
                        m_icnt = 1; m_mode = 1; e_done = fin;
                    end else if (STALL_ON && stall) begin
                        e_im = prev_im;
                    end else begin
                        e_ctr = tab_ctr[m_ph]; e_pe = tab_pe[m_ph]; e_448 = tab_448[m_ph];
                        e_19 = tab_19[m_ph]; e_20 = tab_20[m_ph];
                        if (m_ph == 0 && m_f0) begin e_ctr = 0; e_pe = 0; e_im = 1; end
                        if (m_ph == 1 && m_f1) e_pe = 0;
                        if (m_ph == 0) m_f0 = 0;
                        if (m_ph == 1) m_f1 = 0;
                        if (m_ph == P - 1) begin
                            e_pd = 1; m_blk = (m_blk + 1) % 65536; m_ph = 0;
                            if (fin) begin e_done = 1; m_mode = 0; end
                        end else begin
                            m_ph++;
                        end
                    end
                end
            endcase
        end
        #1;
        chk("raw_saved", input_raw_saved, e_raw);
        chk("ctr_word", ctr_word, e_ctr);
        chk("mem19198_en", mem19198_en_input, e_19);
        chk("mem448_en", mem448_en_input, e_448);
        chk("mem20_en", mem20_en_input, e_20);
        chk("init_mode", mem_init_mode, e_im);
        chk("en_pe", en_pe, e_pe);
        chk("busy", busy, e_busy);
        chk("period_done", period_done, e_pd);
        chk("done", done, e_done);
    end

    logic [3:0] c_arr[10];
    bit pe_arr[10], m20_arr[10], m19_arr[10];

    initial begin
        int n20;
        int pd_cnt;
        int n;
        bit done_seen;
        bit busy_at_done;
        int en_left;

        // Reset with a recognisable input word.
        rst_n = 0; en_init = 0; stall = 0; cfg_blocks = 0; input_raw = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_saved", input_raw_saved, 0);
        chk("rst_ctr", ctr_word, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #2;
        chk("saved_after_rst", input_raw_saved, 32'hDEADBEEF);

        // INIT: hold en_init for 10 edges.
        @(negedge clk) en_init = 1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #2;
            c_arr[j] = ctr_word; pe_arr[j] = en_pe; m20_arr[j] = mem20_en_input;
            m19_arr[j] = mem19198_en_input;
        end
        n20 = 0;
        for (int j = 0; j < 10; j++) n20 += m20_arr[j];
        chk("init_idle_edge_ctr", c_arr[0], 0);
        chk("init_ctr0", c_arr[1], 15);
        chk("init_ctr1", c_arr[2], 0);
        chk("init_pe1", pe_arr[2], 1);
        chk("init_pe2", pe_arr[3], 0);
        chk("init_m20_at5", m20_arr[6], 1);
        chk("init_m20_count", n20, 1);
        chk("init_m19_late", m19_arr[9], 1);

        // Free-running RUN.
        @(negedge clk) begin en_init = 0; cfg_blocks = 0; end
        @(posedge clk);
        #2;
        pd_cnt = 0;
        for (int r = 1; r <= 63; r++) begin
            @(posedge clk);
            #2;
            if (period_done) pd_cnt++;
            if (r == 1) begin
                chk("first_p0_ctr", ctr_word, 0);
                chk("first_p0_pe", en_pe, 0);
                chk("first_p0_im", mem_init_mode, 1);
            end
            if (r == 2) chk("first_p1_pe", en_pe, 0);
            if (r == 25) begin
                chk("p0_ctr", ctr_word, 15);
                chk("p0_pe", en_pe, 1);
            end
            if (r == 30) chk("p5_m20", mem20_en_input, 1);
            if (r == 35) chk("p10_ctr", ctr_word, 1);
            if (r == 48) begin
                chk("p23_ctr", ctr_word, 14);
                chk("p23_m19", mem19198_en_input, 0);
            end
        end
        chk("pd_count", pd_cnt, 2);

        // Abort at phase 15.
        @(negedge clk) en_init = 1;
        @(posedge clk);
        #2;
        chk("abort_ctr", ctr_word, 15);
        chk("abort_pe", en_pe, 1);
        chk("abort_m19", mem19198_en_input, 1);
        chk("abort_done", done, 0);
        chk("abort_pd", period_done, 0);
        repeat (2) @(posedge clk);

        // Counted run of 3 periods; a later cfg_blocks change must be ignored.
        @(negedge clk) begin en_init = 0; cfg_blocks = 3; end
        @(posedge clk);
        #2;
        @(negedge clk) cfg_blocks = 7;
        n = 0; done_seen = 0; busy_at_done = 0;
        while (!done_seen && n < 200) begin
            @(posedge clk);
            #2;
            n++;
            if (done) begin done_seen = 1; busy_at_done = busy; end
        end
        chk("done_latency", n, 72);
        chk("busy_at_done", busy_at_done, 1);
        @(posedge clk);
        #2;
        chk("busy_after_done", busy, 0);

        // Random traffic against the model.
        en_left = 0;
        repeat (3000) begin
            @(negedge clk);
            input_raw = $urandom;
            stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) cfg_blocks = 16'($urandom_range(0, 3));
            if (en_left > 0) begin
                en_init = 1;
                en_left--;
            end else begin
                en_init = 0;
                if ($urandom_range(0, 59) == 0) en_left = $urandom_range(1, 12);
            end
            rst_n = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        rst_n = 1; en_init = 0; stall = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
